bias_stream_sequencer: RTL and testbench

- Per-layer bias controller for the structured-sparse CNN datapath.
- On a start request it drives the 4-bit layer address into the bias lookup tables and captures the returned packed bias word.
- It then streams one signed 16-bit bias per output channel to the accumulator array using a valid/ready handshake.
- It sits between the layer scheduler and the channel-accumulate stage.

---
 rtl/bias_stream_sequencer.sv | 169 ++++++++++++++++
 tb/tb_bias_stream_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/bias_stream_sequencer.sv
// Per-layer bias controller: fetches a packed LUT word and streams one signed bias per channel.
// Optional running bias checksum output guarded by BIAS_CHECKSUM_EN.
module bias_stream_sequencer #(
    parameter int unsigned BIAS_W   = 16,
    parameter int unsigned MAX_CH   = 36,
    parameter int unsigned CH_IDX_W = 6
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [3:0]                 layer,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [3:0]                 lut_addr,
    input  logic [MAX_CH*BIAS_W-1:0]   lut_data,
    output logic [BIAS_W-1:0]          bias_out,
    output logic [CH_IDX_W-1:0]        bias_ch,
    output logic                       bias_valid,
    input  logic                       bias_ready
`ifdef BIAS_CHECKSUM_EN
    ,
    output logic signed [21:0]         bias_sum
`endif
);

    localparam int unsigned WORD_W  = MAX_CH * BIAS_W;
    localparam int unsigned CNT_W   = $clog2(MAX_CH + 1);
    localparam int unsigned SHAMT_W = $clog2(WORD_W);
`ifdef BIAS_CHECKSUM_EN
    localparam int unsigned SUM_W   = 22;
`endif

    typedef enum logic [1:0] {IDLE, FETCH, STREAM, FIN} state_t;

    state_t              state, state_nxt;
    logic [WORD_W-1:0]   shreg, shreg_d;
    logic [CH_IDX_W-1:0] last_ch, last_ch_d;
    logic                busy_d, done_d, err_d, bias_valid_d;
    logic [3:0]          lut_addr_d;
    logic [BIAS_W-1:0]   bias_out_d;
    logic [CH_IDX_W-1:0] bias_ch_d;
    logic [CNT_W-1:0]    req_cnt, cur_cnt;
    logic [WORD_W-1:0]   aligned;
    logic                xfer, xfer_last;
`ifdef BIAS_CHECKSUM_EN
    logic signed [SUM_W-1:0] bias_sum_d;
`endif

    // Channel count per layer; zero marks an invalid layer.
    function automatic logic [CNT_W-1:0] ch_count(input logic [3:0] l);
        case (l)
            4'd1, 4'd2, 4'd3: ch_count = CNT_W'(12);
            4'd4, 4'd5, 4'd6: ch_count = CNT_W'(24);
            4'd7, 4'd8:       ch_count = CNT_W'(36);
            4'd9:             ch_count = CNT_W'(10);
            default:          ch_count = CNT_W'(0);
        endcase
    endfunction

    assign req_cnt   = ch_count(layer);
    assign cur_cnt   = ch_count(lut_addr);
    assign xfer      = (state == STREAM) && bias_valid && bias_ready;
    assign xfer_last = xfer && (bias_ch == last_ch);

    // Left-justify the layer's word so channel 0 sits in the top slice.
    assign aligned = lut_data << SHAMT_W'((MAX_CH - 32'(cur_cnt)) * BIAS_W);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && (req_cnt != '0)) state_nxt = FETCH;
            FETCH:   state_nxt = STREAM;
            STREAM:  if (xfer_last) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_d       = busy;
        done_d       = 1'b0;
        err_d        = 1'b0;
        lut_addr_d   = lut_addr;
        bias_out_d   = bias_out;
        bias_ch_d    = bias_ch;
        bias_valid_d = bias_valid;
        shreg_d      = shreg;
        last_ch_d    = last_ch;
`ifdef BIAS_CHECKSUM_EN
        bias_sum_d   = bias_sum;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    if (req_cnt != '0) begin
                        lut_addr_d = layer;
                        busy_d     = 1'b1;
`ifdef BIAS_CHECKSUM_EN
                        bias_sum_d = '0;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            FETCH: begin
                shreg_d      = aligned;
                bias_out_d   = aligned[WORD_W-1 -: BIAS_W];
                bias_ch_d    = '0;
                bias_valid_d = 1'b1;
                last_ch_d    = CH_IDX_W'(cur_cnt - CNT_W'(1));
            end
            STREAM: begin
                if (xfer) begin
`ifdef BIAS_CHECKSUM_EN
                    bias_sum_d = bias_sum + SUM_W'($signed(bias_out));
`endif
                    if (xfer_last) begin
                        bias_valid_d = 1'b0;
                        done_d       = 1'b1;
                        busy_d       = 1'b0;
                    end else begin
                        shreg_d    = shreg << BIAS_W;
                        bias_out_d = shreg[WORD_W-BIAS_W-1 -: BIAS_W];
                        bias_ch_d  = bias_ch + CH_IDX_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            lut_addr   <= '0;
            bias_out   <= '0;
            bias_ch    <= '0;
            bias_valid <= 1'b0;
            shreg      <= '0;
            last_ch    <= '0;
`ifdef BIAS_CHECKSUM_EN
            bias_sum   <= '0;
`endif
        end else begin
            busy       <= busy_d;
            done       <= done_d;
            err        <= err_d;
            lut_addr   <= lut_addr_d;
            bias_out   <= bias_out_d;
            bias_ch    <= bias_ch_d;
            bias_valid <= bias_valid_d;
            shreg      <= shreg_d;
            last_ch    <= last_ch_d;
`ifdef BIAS_CHECKSUM_EN
            bias_sum   <= bias_sum_d;
`endif
        end
    end

endmodule

// File: tb/tb_bias_stream_sequencer.sv
// Self-checking bench for bias_stream_sequencer against a table-driven LUT and stream model.
module tb_bias_stream_sequencer;

    localparam int BIAS_W = 16;
    localparam int MAX_CH = 36;
    localparam int CH_IDX_W = 6;

    logic clk, rst_n, start, busy, done, err, bias_valid, bias_ready;
    logic [3:0] layer, lut_addr;
    logic [MAX_CH*BIAS_W-1:0] lut_data;
    logic [BIAS_W-1:0] bias_out;
    logic [CH_IDX_W-1:0] bias_ch;
`ifdef BIAS_CHECKSUM_EN
    logic signed [21:0] bias_sum;
`endif

    int checks = 0;
    int failures = 0;
    int exp_addr = 0;
    logic [15:0] tbl [0:15][0:35];

    bias_stream_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .layer(layer),
        .busy(busy), .done(done), .err(err), .lut_addr(lut_addr),
        .lut_data(lut_data), .bias_out(bias_out), .bias_ch(bias_ch),
        .bias_valid(bias_valid), .bias_ready(bias_ready)
`ifdef BIAS_CHECKSUM_EN
        , .bias_sum(bias_sum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int nch(input int l);
        if (l >= 1 && l <= 3) return 12;
        if (l >= 4 && l <= 6) return 24;
        if (l == 7 || l == 8) return 36;
        if (l == 9) return 10;
        return 0;
    endfunction

    // Behavioural LUT: channel k of an n-channel layer at slice n-1-k.
    always_comb begin
        lut_data = '0;
        for (int k = 0; k < 36; k++)
            if (k < nch(int'(lut_addr)))
                lut_data[(nch(int'(lut_addr)) - 1 - k) * 16 +: 16] = tbl[lut_addr][k];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 64'(busy), 0);
        check({tag, "_done"}, 64'(done), 0);
        check({tag, "_err"}, 64'(err), 0);
        check({tag, "_addr"}, 64'(lut_addr), 0);
        check({tag, "_out"}, 64'(bias_out), 0);
        check({tag, "_ch"}, 64'(bias_ch), 0);
        check({tag, "_valid"}, 64'(bias_valid), 0);
`ifdef BIAS_CHECKSUM_EN
        check({tag, "_sum"}, 64'(bias_sum), 0);
`endif
    endtask

    // mode: 0 ready high, 1 ready toggling, 2 ready random
    task automatic run_layer(input int l, input int mode, input int restart_at, input int abort_at);
        int n;
        int idx;
        int cyc;
        int sum;
        logic rdy;
        n = nch(l);
        idx = 0;
        sum = 0;
        layer = 4'(l);
        start = 1'b1;
        bias_ready = 1'b1;
        step();
        start = 1'b0;
        cyc = 1;
        exp_addr = l;
        check("busy_on", 64'(busy), 1);
        check("valid_early", 64'(bias_valid), 0);
        check("addr_drive", 64'(lut_addr), 64'(l));
        step();
        cyc = 2;
        forever begin
            if (idx == n) begin
                check("done_pulse", 64'(done), 1);
                check("busy_at_done", 64'(busy), 0);
                check("valid_at_done", 64'(bias_valid), 0);
                if (mode == 0) check("latency", 64'(cyc), 64'(n + 2));
`ifdef BIAS_CHECKSUM_EN
                check("bias_sum", 64'(bias_sum), 64'(22'(sum)));
`endif
                break;
            end
            check("done_early", 64'(done), 0);
            check("busy_mid", 64'(busy), 1);
            check("err_mid", 64'(err), 0);
            check("valid_mid", 64'(bias_valid), 1);
            check("bias_ch", 64'(bias_ch), 64'(idx));
            check("bias_out", 64'(bias_out), 64'(tbl[l][idx]));
            if (idx == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_all_zero("abort");
                step();
                check("abort_no_done", 64'(done), 0);
                rst_n = 1'b1;
                exp_addr = 0;
                step();
                return;
            end
            if (cyc == restart_at) begin
                start = 1'b1;
                layer = 4'd2;
            end else begin
                start = 1'b0;
            end
            case (mode)
                0: rdy = 1'b1;
                1: rdy = (cyc % 2) == 0;
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            bias_ready = rdy;
            step();
            cyc++;
            if (rdy) begin
                sum += int'($signed(tbl[l][idx]));
                idx++;
            end
            if (cyc > 4 * n + 40) begin
                check("stream_timeout", 64'(idx), 64'(n));
                break;
            end
        end
        start = 1'b0;
        step();
        check("done_once", 64'(done), 0);
        check("busy_after", 64'(busy), 0);
        check("addr_hold", 64'(lut_addr), 64'(l));
    endtask

    task automatic bad_start(input int l);
        layer = 4'(l);
        start = 1'b1;
        step();
        start = 1'b0;
        check("err_pulse", 64'(err), 1);
        check("err_busy", 64'(busy), 0);
        check("err_valid", 64'(bias_valid), 0);
        check("err_addr", 64'(lut_addr), 64'(exp_addr));
        step();
        check("err_clear", 64'(err), 0);
        check("err_addr2", 64'(lut_addr), 64'(exp_addr));
    endtask

    initial begin
        logic [15:0] l1 [0:11];
        l1 = '{16'd1, 16'd125, 16'd39, 16'd3, 16'hFFF0, 16'd1,
               16'd65, 16'hFFE4, 16'd100, 16'd49, 16'd27, 16'd68};
        rst_n = 1'b0;
        start = 1'b0;
        layer = 4'd0;
        bias_ready = 1'b0;
        for (int a = 0; a < 16; a++)
            for (int k = 0; k < 36; k++)
                tbl[a][k] = 16'($urandom());
        for (int k = 0; k < 12; k++) tbl[1][k] = l1[k];
        tbl[9][0] = 16'hFFF0;
        tbl[9][9] = 16'hFFF2;

        step();
        step();
        check_all_zero("reset");
        rst_n = 1'b1;
        step();
        check_all_zero("post_reset");

        run_layer(1, 0, -1, -1);
        run_layer(9, 1, -1, -1);
        bad_start(0);
        bad_start(12);
        bad_start(15);
        run_layer(7, 2, 10, -1);
        run_layer(4, 0, -1, 4);
        check_all_zero("after_abort");
        run_layer(4, 0, -1, -1);
        for (int i = 0; i < 6; i++)
            run_layer(int'($urandom_range(1, 9)), 2, -1, -1);
        bad_start(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
